debouncer_multi: RTL and testbench



---
 rtl/debouncer_multi.sv | 117 +++++++++++
 tb/tb_debouncer_multi.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// Multi-channel debounce filter for asynchronous button/switch inputs.
// Each channel has its own synchroniser chain, stability counter, debounced
// level with registered rise/fall strobes, and a long-press hold flag.
// Channels share nothing but the clock and reset.
module debouncer_multi #(
  parameter int              CH_N        = 4,
  parameter int              DELAY       = 1000000,
  parameter int              SYNC_STAGES = 2,
  parameter logic [CH_N-1:0] RST_VAL     = '0,
  parameter int              HOLD_DELAY  = 50000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH_N-1:0] din,
  output logic [CH_N-1:0] dout,
  output logic [CH_N-1:0] rise,
  output logic [CH_N-1:0] fall,
  output logic [CH_N-1:0] hold
);

  localparam int CNT_W  = (DELAY > 1)      ? $clog2(DELAY)      : 1;
  localparam int HCNT_W = (HOLD_DELAY > 1) ? $clog2(HOLD_DELAY) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HOLD_DELAY - 1);
  localparam logic [HCNT_W-1:0] HCNT_ONE = HCNT_W'(1);

  logic [CH_N-1:0]   sync_q [SYNC_STAGES];
  logic [CH_N-1:0]   din_s;
  logic [CH_N-1:0]   samp;
  logic [CNT_W-1:0]  cnt    [CH_N];
  logic [HCNT_W-1:0] hcnt   [CH_N];
  logic [CH_N-1:0]   dout_next;

  assign din_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: bring each raw pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RST_VAL;
      end
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Stability tracking: any change of the synced level restarts the count,
  // otherwise count up and park at DELAY-1 once the level is proven stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp <= RST_VAL;
      for (int i = 0; i < CH_N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_N; i++) begin
        if (din_s[i] != samp[i]) begin
          samp[i] <= din_s[i];
          cnt[i]  <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Next debounced level: adopt the sampled level only when it has survived
  // the full stability window; a fresh change on this edge takes priority.
  always_comb begin
    dout_next = dout;
    for (int i = 0; i < CH_N; i++) begin
      if ((din_s[i] == samp[i]) && (cnt[i] == CNT_MAX)) begin
        dout_next[i] = samp[i];
      end
    end
  end

  // Debounced level and its edge strobes, registered together so a strobe
  // is high for exactly the first cycle of the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= RST_VAL;
      rise <= '0;
      fall <= '0;
    end else begin
      dout <= dout_next;
      rise <= dout_next & ~dout;
      fall <= ~dout_next & dout;
    end
  end

  // Long-press tracking: count cycles spent high, flag once the count has
  // saturated, and drop the flag on the same edge the level falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      for (int i = 0; i < CH_N; i++) begin
        hcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_N; i++) begin
        if (!dout[i]) begin
          hcnt[i] <= '0;
        end else if (hcnt[i] != HCNT_MAX) begin
          hcnt[i] <= hcnt[i] + HCNT_ONE;
        end
        hold[i] <= dout_next[i] & (hold[i] | (dout[i] & (hcnt[i] == HCNT_MAX)));
      end
    end
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: directed scenarios plus random input traffic,
// all compared against a run-length reference model of the debounce rules.
module tb_debouncer_multi;

  localparam int         CH_N        = 4;
  localparam int         DELAY       = 8;
  localparam int         SYNC_STAGES = 2;
  localparam logic [3:0] RST_VAL     = 4'b0001;
  localparam int         HOLD_DELAY  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] din = 4'b0001;
  logic [3:0] dout, rise, fall, hold;

  int errors = 0;
  int checks = 0;

  debouncer_multi #(
    .CH_N       (CH_N),
    .DELAY      (DELAY),
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (RST_VAL),
    .HOLD_DELAY (HOLD_DELAY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .hold (hold)
  );

  always #5 clk = ~clk;

  // Reference model: the synced input seen at an edge is the din applied
  // SYNC_STAGES edges earlier; dout adopts a level once that synced level has
  // been seen on DELAY+1 consecutive edges; hold means dout was 1 on at
  // least HOLD_DELAY consecutive edges and is still 1.
  logic [3:0] m_q[$];
  logic [3:0] m_runv;
  int         m_run [4];
  int         m_hr  [4];
  logic [3:0] m_dout, m_rise, m_fall, m_hold;

  task automatic model_reset();
    m_q.delete();
    for (int k = 0; k < SYNC_STAGES; k++) m_q.push_back(RST_VAL);
    m_runv = RST_VAL;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 1;
      m_hr[i]  = 0;
    end
    m_dout = RST_VAL;
    m_rise = '0;
    m_fall = '0;
    m_hold = '0;
  endtask

  task automatic model_step(input logic [3:0] d);
    logic [3:0] s;
    logic       nd;
    s = m_q.pop_front();
    m_q.push_back(d);
    for (int i = 0; i < 4; i++) begin
      if (s[i] == m_runv[i]) begin
        if (m_run[i] < 1000) m_run[i]++;
      end else begin
        m_runv[i] = s[i];
        m_run[i]  = 1;
      end
      nd = (m_run[i] >= DELAY + 1) ? m_runv[i] : m_dout[i];
      if (m_dout[i]) begin
        if (m_hr[i] < 1000) m_hr[i]++;
      end else begin
        m_hr[i] = 0;
      end
      m_rise[i] = nd & ~m_dout[i];
      m_fall[i] = ~nd & m_dout[i];
      m_hold[i] = nd & (m_hr[i] >= HOLD_DELAY);
      m_dout[i] = nd;
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(din);
    #1;
  endtask

  task automatic test_reset();
    din = 4'b0001;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 4'b0001 || rise !== 4'b0 || fall !== 4'b0 || hold !== 4'b0) begin
      errors++;
      $display("FAIL reset_values: dout=%b rise=%b fall=%b hold=%b, want dout=0001 others 0000", dout, rise, fall, hold);
    end
    for (int t = 0; t < 3; t++) tick();
    checks++;
    if (dout !== 4'b0001 || rise !== 4'b0 || fall !== 4'b0 || hold !== 4'b0) begin
      errors++;
      $display("FAIL reset_held: dout=%b rise=%b fall=%b hold=%b, want dout=0001 others 0000", dout, rise, fall, hold);
    end
    rst_n = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if (rise !== 4'b0 || fall !== 4'b0) begin
        errors++;
        $display("FAIL reset_no_strobe t=%0d: rise=%b fall=%b, want 0000 0000", t, rise, fall);
      end
      checks++;
      if ({dout, rise, fall, hold} !== {m_dout, m_rise, m_fall, m_hold}) begin
        errors++;
        $display("FAIL reset_model t=%0d: got %b/%b/%b/%b, want %b/%b/%b/%b", t, dout, rise, fall, hold, m_dout, m_rise, m_fall, m_hold);
      end
    end
  endtask

  task automatic test_clean_press();
    din[1] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if (t < 11 && (dout[1] !== 1'b0 || rise[1] !== 1'b0)) begin
        errors++;
        $display("FAIL press_early t=%0d: dout1=%b rise1=%b, want 0 0", t, dout[1], rise[1]);
      end else if (t == 11 && (dout[1] !== 1'b1 || rise[1] !== 1'b1)) begin
        errors++;
        $display("FAIL press_edge11: dout1=%b rise1=%b, want 1 1", dout[1], rise[1]);
      end else if (t == 12 && (dout[1] !== 1'b1 || rise[1] !== 1'b0)) begin
        errors++;
        $display("FAIL press_edge12: dout1=%b rise1=%b, want 1 0", dout[1], rise[1]);
      end
      checks++;
      if ({dout, rise, fall, hold} !== {m_dout, m_rise, m_fall, m_hold}) begin
        errors++;
        $display("FAIL press_model t=%0d: got %b/%b/%b/%b, want %b/%b/%b/%b", t, dout, rise, fall, hold, m_dout, m_rise, m_fall, m_hold);
      end
    end
  endtask

  task automatic test_hold();
    // Rise was seen 11 edges after the press; hold is due 20 edges later.
    for (int t = 13; t <= 31; t++) begin
      tick();
      checks++;
      if (hold[1] !== (t == 31)) begin
        errors++;
        $display("FAIL hold_assert t=%0d: hold1=%b, want %b", t, hold[1], (t == 31));
      end
      checks++;
      if ({dout, rise, fall, hold} !== {m_dout, m_rise, m_fall, m_hold}) begin
        errors++;
        $display("FAIL hold_model t=%0d: got %b/%b/%b/%b, want %b/%b/%b/%b", t, dout, rise, fall, hold, m_dout, m_rise, m_fall, m_hold);
      end
    end
    din[1] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if (t < 11 && (hold[1] !== 1'b1 || fall[1] !== 1'b0)) begin
        errors++;
        $display("FAIL release_early t=%0d: hold1=%b fall1=%b, want 1 0", t, hold[1], fall[1]);
      end else if (t == 11 && (hold[1] !== 1'b0 || fall[1] !== 1'b1 || dout[1] !== 1'b0)) begin
        errors++;
        $display("FAIL release_edge: hold1=%b fall1=%b dout1=%b, want 0 1 0", hold[1], fall[1], dout[1]);
      end
      checks++;
      if ({dout, rise, fall, hold} !== {m_dout, m_rise, m_fall, m_hold}) begin
        errors++;
        $display("FAIL release_model t=%0d: got %b/%b/%b/%b, want %b/%b/%b/%b", t, dout, rise, fall, hold, m_dout, m_rise, m_fall, m_hold);
      end
    end
  endtask

  task automatic test_bounce();
    for (int t = 0; t < 30; t++) begin
      if (t % 3 == 0) din[2] = ~din[2];
      tick();
      checks++;
      if (rise[2] !== 1'b0 || fall[2] !== 1'b0 || dout[2] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_quiet t=%0d: dout2=%b rise2=%b fall2=%b, want 0 0 0", t, dout[2], rise[2], fall[2]);
      end
      checks++;
      if ({dout, rise, fall, hold} !== {m_dout, m_rise, m_fall, m_hold}) begin
        errors++;
        $display("FAIL bounce_model t=%0d: got %b/%b/%b/%b, want %b/%b/%b/%b", t, dout, rise, fall, hold, m_dout, m_rise, m_fall, m_hold);
      end
    end
    din[2] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if (rise[2] !== (t == 11)) begin
        errors++;
        $display("FAIL bounce_settle t=%0d: rise2=%b, want %b", t, rise[2], (t == 11));
      end
      checks++;
      if ({dout, rise, fall, hold} !== {m_dout, m_rise, m_fall, m_hold}) begin
        errors++;
        $display("FAIL settle_model t=%0d: got %b/%b/%b/%b, want %b/%b/%b/%b", t, dout, rise, fall, hold, m_dout, m_rise, m_fall, m_hold);
      end
    end
  endtask

  task automatic test_simultaneous();
    din[3] = 1'b1;
    din[0] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if (t == 11 && (rise !== 4'b1000 || fall !== 4'b0001 || dout !== 4'b1100)) begin
        errors++;
        $display("FAIL simul_edge: rise=%b fall=%b dout=%b, want 1000 0001 1100", rise, fall, dout);
      end else if (t != 11 && (rise !== 4'b0 || fall !== 4'b0)) begin
        errors++;
        $display("FAIL simul_quiet t=%0d: rise=%b fall=%b, want 0000 0000", t, rise, fall);
      end
      checks++;
      if ({dout, rise, fall, hold} !== {m_dout, m_rise, m_fall, m_hold}) begin
        errors++;
        $display("FAIL simul_model t=%0d: got %b/%b/%b/%b, want %b/%b/%b/%b", t, dout, rise, fall, hold, m_dout, m_rise, m_fall, m_hold);
      end
    end
  endtask

  task automatic test_mid_reset();
    din[1] = 1'b1;
    // Edge 3 loads the sample register, so edge 8 leaves the count at 5.
    for (int t = 1; t <= 8; t++) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dout !== RST_VAL || rise !== 4'b0 || fall !== 4'b0 || hold !== 4'b0) begin
      errors++;
      $display("FAIL midrst_async: dout=%b rise=%b fall=%b hold=%b, want 0001 0000 0000 0000", dout, rise, fall, hold);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if (t < 11 && dout !== RST_VAL) begin
        errors++;
        $display("FAIL midrst_wait t=%0d: dout=%b, want 0001", t, dout);
      end else if (t == 11 && (dout !== 4'b1110 || rise !== 4'b1110 || fall !== 4'b0001)) begin
        errors++;
        $display("FAIL midrst_edge: dout=%b rise=%b fall=%b, want 1110 1110 0001", dout, rise, fall);
      end
      checks++;
      if ({dout, rise, fall, hold} !== {m_dout, m_rise, m_fall, m_hold}) begin
        errors++;
        $display("FAIL midrst_model t=%0d: got %b/%b/%b/%b, want %b/%b/%b/%b", t, dout, rise, fall, hold, m_dout, m_rise, m_fall, m_hold);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 900; t++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 11) == 0) din[i] = ~din[i];
      end
      tick();
      checks++;
      if ({dout, rise, fall, hold} !== {m_dout, m_rise, m_fall, m_hold}) begin
        errors++;
        $display("FAIL random_model t=%0d din=%b: got %b/%b/%b/%b, want %b/%b/%b/%b", t, din, dout, rise, fall, hold, m_dout, m_rise, m_fall, m_hold);
      end
      checks++;
      if ((rise & fall) !== 4'b0) begin
        errors++;
        $display("FAIL random_rise_fall t=%0d: rise&fall=%b, want 0000", t, rise & fall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_hold();
    test_bounce();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
